// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_pkg;

  // Operation encodings as presented on the op input.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Radix-2 steps per operation (one per operand bit).
  localparam int ITER = 32;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Divides are distinguished from multiplies by the upper op bit.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // MULT and DIV treat their operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: acc = {partial product high, remaining multiplier bits};
//   conditionally add the multiplicand to the high half, then shift right.
// Divide: acc = {partial remainder, remaining dividend / quotient bits};
//   shift left one bit, subtract the divisor if it fits, shift in the quotient bit.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_new;

  // Multiply path: carry out of the add becomes the new top bit after the shift.
  assign w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};

  // Divide path: partial remainder shifted left with the next dividend bit.
  // When the divisor fits, the difference is below the divisor and so fits in WIDTH bits.
  assign w_rem_sh  = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_fits    = (w_rem_sh >= {1'b0, i_opnd});
  assign w_rem_new = w_rem_sh[WIDTH-1:0] - i_opnd;

  // Select the iteration result for the current operation class.
  always_comb begin
    o_acc = i_acc;
    if (i_is_div) begin
      if (w_fits) begin
        o_acc = {w_rem_new, i_acc[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      if (i_acc[0]) begin
        o_acc = {w_sum, i_acc[WIDTH-1:1]};
      end else begin
        o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Fixed latency: start sampled at edge 0, 32 iterations on edges 1..32,
// sign/exception fixup and HI/LO write at edge 33 with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting; accepts start or MTHI/MTLO writes
// RUN   | one radix-2 iteration per cycle, 32 cycles
// FIX   | sign correction / divide-by-zero override, write HI/LO, pulse done
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] CNT_LAST = 6'(ITER - 1);

  state_t             r_state;
  logic [5:0]         r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_a_raw;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_div_zero;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_is_div;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Operand conditioning at launch: magnitudes for signed ops, raw for unsigned.
  assign w_is_div = op_is_div(op);
  assign w_signed = op_is_signed(op);
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_abs_a  = w_a_neg ? -a : a;
  assign w_abs_b  = w_b_neg ? -b : b;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_acc_next)
  );

  // Sign correction works on magnitudes; the most-negative value negates to itself,
  // which is exactly the modulo-2^32 result wanted for DIV 0x80000000 / -1.
  assign w_prod = r_neg_lo ? -r_acc : r_acc;
  assign w_quot = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // Final HI/LO values, including the divide-by-zero override.
  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div_zero) begin
        w_fix_hi = r_a_raw;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = w_rem;
        w_fix_lo = w_quot;
      end
    end
  end

  // Controller, iteration counter and operand/accumulator latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_a_raw    <= '0;
      r_is_div   <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_div_zero <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= RUN;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_is_div   <= w_is_div;
            r_a_raw    <= a;
            r_div_zero <= w_is_div && (b == '0);
            r_neg_lo   <= w_a_neg ^ w_b_neg;
            r_neg_hi   <= w_is_div ? w_a_neg : (w_a_neg ^ w_b_neg);
            if (w_is_div) begin
              r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
              r_opnd <= w_abs_b;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
              r_opnd <= w_abs_a;
            end
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == CNT_LAST) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // HI/LO: written by the fixup, or by MTHI/MTLO when idle and not starting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == FIX) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end else if ((r_state == IDLE) && !start) begin
      if (mthi) begin
        r_hi <= a;
      end
      if (mtlo) begin
        r_lo <= a;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {hi, lo} from MIPS semantics using 64-bit arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = '0;
    case (o)
      2'd0: p = 64'(sx * sy);
      2'd1: p = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  // Launch one operation and follow it to done; checks busy and HI/LO hold during the run.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic with_mthi,
                        output logic [31:0] rh, output logic [31:0] rl, output int lat);
    logic [31:0] h0, l0;
    int hold_err;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1; mthi = with_mthi;
    h0 = hi; l0 = lo;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    lat = 0; hold_err = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1 || hi !== h0 || lo !== l0) hold_err++;
      @(posedge clk); #1;
      lat++;
    end
    rh = hi; rl = lo;
    total++;
    if (hold_err != 0) begin
      bad++;
      $display("FAIL run_hold op=%0d a=%h b=%h errors=%0d required 0", o, x, y, hold_err);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_at_done op=%0d got %b required 0", o, busy);
    end
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b required 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b required 0", done); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got %h required 0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got %h required 0", lo); end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [8] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
    logic [31:0] as  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9,
                             32'd100, 32'd5, 32'h80000000, 32'd7};
    logic [31:0] bs  [8] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd2,
                             32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] eh  [8] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF,
                             32'd2, 32'd5, 32'd0, 32'd1};
    logic [31:0] el  [8] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000000, 32'hFFFFFFFD,
                             32'd14, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD};
    logic [31:0] rh, rl;
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, rh, rl, lat);
      total++; if (lat != 33) begin bad++; $display("FAIL dir_latency #%0d got %0d required 33", i, lat); end
      total++; if (rh !== eh[i]) begin bad++; $display("FAIL dir_hi #%0d got %h required %h", i, rh, eh[i]); end
      total++; if (rl !== el[i]) begin bad++; $display("FAIL dir_lo #%0d got %h required %h", i, rl, el[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] specials [5] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] x, y, rh, rl;
    logic [1:0]  o;
    logic [63:0] exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      case ($urandom_range(0, 5))
        0:       y = specials[$urandom_range(0, 4)];
        1:       y = 32'($urandom_range(0, 20));
        default: y = $urandom;
      endcase
      exp = ref_op(o, x, y);
      run_op(o, x, y, 1'b0, rh, rl, lat);
      total++; if (lat != 33) begin bad++; $display("FAIL rnd_latency op=%0d got %0d required 33", o, lat); end
      total++;
      if ({rh, rl} !== exp) begin
        bad++;
        $display("FAIL rnd_result op=%0d a=%h b=%h got %h_%h required %h_%h", o, x, y, rh, rl, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat, done_cnt;
    logic [31:0] rh, rl;
    @(negedge clk);
    op = 2'd1; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; done_cnt = 0;
    rh = 32'hx; rl = 32'hx;
    while (lat < 80) begin
      if (lat == 9)  begin start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7; end
      if (lat == 10) start = 1'b0;
      if (lat == 11) begin mthi = 1'b1; a = 32'h0000DEAD; end
      if (lat == 12) mthi = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          rh = hi; rl = lo;
          total++; if (lat != 33) begin bad++; $display("FAIL ign_latency got %0d required 33", lat); end
        end
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ign_done_count got %0d required 1", done_cnt); end
    total++; if (rl !== 32'd12) begin bad++; $display("FAIL ign_lo got %h required 0000000c", rl); end
    total++; if (rh !== 32'd0) begin bad++; $display("FAIL ign_hi got %h required 0", rh); end
  endtask

  task automatic test_rst_mid();
    int lat, done_cnt;
    @(negedge clk);
    op = 2'd2; a = 32'hFFFFFF00; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (lat < 15) begin @(posedge clk); #1; lat++; end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b required 0", busy); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL rst_hi got %h required 0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL rst_lo got %h required 0", lo); end
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL rst_no_done got %0d active cycles required 0", done_cnt); end
    @(negedge clk);
    a = 32'h00001234; mtlo = 1'b1;
    @(posedge clk); #1;
    mtlo = 1'b0;
    total++; if (lo !== 32'h00001234) begin bad++; $display("FAIL rst_mtlo got %h required 00001234", lo); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL rst_mtlo_hi got %h required 0", hi); end
  endtask

  task automatic test_moves();
    logic [31:0] x, y, rh, rl;
    int lat;
    x = $urandom; y = $urandom;
    @(negedge clk);
    a = x; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    total++; if (hi !== x) begin bad++; $display("FAIL mt_both_hi got %h required %h", hi, x); end
    total++; if (lo !== x) begin bad++; $display("FAIL mt_both_lo got %h required %h", lo, x); end
    @(negedge clk);
    a = y; mthi = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0;
    total++; if (hi !== y) begin bad++; $display("FAIL mthi_hi got %h required %h", hi, y); end
    total++; if (lo !== x) begin bad++; $display("FAIL mthi_lo got %h required %h", lo, x); end
    // start and mthi together: the move is dropped, hi only changes at the result
    run_op(2'd1, 32'd6, 32'd7, 1'b1, rh, rl, lat);
    total++; if (rh !== 32'd0) begin bad++; $display("FAIL start_mthi_hi got %h required 0", rh); end
    total++; if (rl !== 32'd42) begin bad++; $display("FAIL start_mthi_lo got %h required 0000002a", rl); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rh, rl;
    logic [63:0] exp;
    int lat;
    run_op(2'd0, 32'hFFFFFFF0, 32'd5, 1'b0, rh, rl, lat);
    // Next launch lands on the edge right after done.
    exp = ref_op(2'd3, 32'd1000, 32'd33);
    run_op(2'd3, 32'd1000, 32'd33, 1'b0, rh, rl, lat);
    total++; if (lat != 33) begin bad++; $display("FAIL b2b_latency got %0d required 33", lat); end
    total++; if ({rh, rl} !== exp) begin bad++; $display("FAIL b2b_result got %h_%h required %h_%h", rh, rl, exp[63:32], exp[31:0]); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_random();
    test_start_ignored();
    test_rst_mid();
    test_moves();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
